// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with fixed-priority and round-robin modes,
// one-deep output stage with valid/ready handshake on both sides.
module priority_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_none,
    output logic         out_multi
);

    logic [W-1:0] ptr;
    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;
    logic [W-1:0] fp_idx;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win_idx;
    logic [W-1:0] ptr_next;
    logic         any_req;
    logic         multi_req;
    logic         accept;

    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Round-robin: prefer requests at or above ptr, otherwise wrap to the lowest set bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (W'(i) >= ptr);
        end
        upper_req = d & upper_mask;
        fp_idx    = lowest_set(d);
        rr_idx    = (|upper_req) ? lowest_set(upper_req) : fp_idx;
        win_idx   = mode ? rr_idx : fp_idx;
        any_req   = |d;
        multi_req = |(d & (d - N'(1)));
        ptr_next  = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
            out_multi <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (en && any_req) begin
                out_idx   <= win_idx;
                out_none  <= 1'b0;
                out_multi <= multi_req;
                if (mode) ptr <= ptr_next;
            end else begin
                out_idx   <= '0;
                out_none  <= 1'b1;
                out_multi <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed self-checking bench for priority_encoder_rr at N=8.
module tb_priority_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] d;
    logic         en;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         out_none;
    logic         out_multi;

    int tests = 0;
    int fails = 0;

    priority_encoder_rr #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_none  (out_none),
        .out_multi (out_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, out_idx[2:0], out_none, out_multi}
    function automatic logic [5:0] obs();
        return {out_valid, out_idx, out_none, out_multi};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic e, input logic m, input logic [N-1:0] dd);
        in_valid  = 1'b1;
        en        = e;
        mode      = m;
        d         = dd;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; en = 1'b1; mode = 1'b1; d = 8'hFF; out_ready = 1'b1;
        tick();
        tick();
        tests++;
        if (obs() !== 6'b0_000_0_0) begin
            fails++; $display("FAIL reset_outputs: got %b exp %b", obs(), 6'b0_000_0_0);
        end
        tests++;
        if (dut.ptr !== 3'd0) begin
            fails++; $display("FAIL reset_ptr: got %0d exp %0d", dut.ptr, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b exp %b", in_ready, 1'b1);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_idle_valid: got %b exp %b", out_valid, 1'b0);
        end
    endtask

    task automatic test_fixed();
        send(1'b1, 1'b0, 8'b0000_0100);
        tests++;
        if (obs() !== 6'b1_010_0_0) begin
            fails++; $display("FAIL fixed_single: got %b exp %b", obs(), 6'b1_010_0_0);
        end
        send(1'b1, 1'b0, 8'b1001_0010);
        tests++;
        if (obs() !== 6'b1_001_0_1) begin
            fails++; $display("FAIL fixed_multi: got %b exp %b", obs(), 6'b1_001_0_1);
        end
        tests++;
        if (dut.ptr !== 3'd0) begin
            fails++; $display("FAIL fixed_ptr: got %0d exp %0d", dut.ptr, 0);
        end
        send(1'b1, 1'b0, 8'h00);
        tests++;
        if (obs() !== 6'b1_000_1_0) begin
            fails++; $display("FAIL fixed_zero: got %b exp %b", obs(), 6'b1_000_1_0);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [3] = '{3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b1, 8'hFF);
            tests++;
            if (obs() !== {1'b1, exp_idx[i], 1'b0, 1'b1}) begin
                fails++; $display("FAIL rr_ff_%0d: got %b exp %b", i, obs(), {1'b1, exp_idx[i], 1'b0, 1'b1});
            end
        end
        tests++;
        if (dut.ptr !== 3'd3) begin
            fails++; $display("FAIL rr_ptr3: got %0d exp %0d", dut.ptr, 3);
        end
        send(1'b1, 1'b1, 8'b1000_0001);
        tests++;
        if (obs() !== 6'b1_111_0_1) begin
            fails++; $display("FAIL rr_top: got %b exp %b", obs(), 6'b1_111_0_1);
        end
        tests++;
        if (dut.ptr !== 3'd0) begin
            fails++; $display("FAIL rr_wrap_ptr: got %0d exp %0d", dut.ptr, 0);
        end
        send(1'b1, 1'b1, 8'b1000_0001);
        tests++;
        if (obs() !== 6'b1_000_0_1) begin
            fails++; $display("FAIL rr_after_wrap: got %b exp %b", obs(), 6'b1_000_0_1);
        end
    endtask

    task automatic test_no_encode();
        send(1'b0, 1'b1, 8'h10);
        tests++;
        if (obs() !== 6'b1_000_1_0) begin
            fails++; $display("FAIL en0: got %b exp %b", obs(), 6'b1_000_1_0);
        end
        send(1'b1, 1'b1, 8'h00);
        tests++;
        if (obs() !== 6'b1_000_1_0) begin
            fails++; $display("FAIL rr_zero: got %b exp %b", obs(), 6'b1_000_1_0);
        end
        tests++;
        if (dut.ptr !== 3'd1) begin
            fails++; $display("FAIL no_encode_ptr: got %0d exp %0d", dut.ptr, 1);
        end
    endtask

    task automatic test_mode_switch();
        send(1'b1, 1'b0, 8'b0000_0001);
        tests++;
        if (obs() !== 6'b1_000_0_0 || dut.ptr !== 3'd1) begin
            fails++; $display("FAIL switch_fixed: got %b ptr %0d exp %b ptr 1", obs(), dut.ptr, 6'b1_000_0_0);
        end
        send(1'b1, 1'b1, 8'b0100_0001);
        tests++;
        if (obs() !== 6'b1_110_0_1 || dut.ptr !== 3'd7) begin
            fails++; $display("FAIL switch_rr: got %b ptr %0d exp %b ptr 7", obs(), dut.ptr, 6'b1_110_0_1);
        end
        send(1'b1, 1'b1, 8'b1000_0000);
        tests++;
        if (obs() !== 6'b1_111_0_0 || dut.ptr !== 3'd0) begin
            fails++; $display("FAIL switch_wrap: got %b ptr %0d exp %b ptr 0", obs(), dut.ptr, 6'b1_111_0_0);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] pattern [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        out_ready = 1'b0; in_valid = 1'b1; en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = pattern[i];
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_ready_%0d: got %b exp %b", i, in_ready, 1'b0);
            end
            tick();
            tests++;
            if (obs() !== 6'b1_111_0_0) begin
                fails++; $display("FAIL stall_hold_%0d: got %b exp %b", i, obs(), 6'b1_111_0_0);
            end
        end
        out_ready = 1'b1; d = 8'b0010_0000;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL release_ready: got %b exp %b", in_ready, 1'b1);
        end
        tick();
        tests++;
        if (obs() !== 6'b1_101_0_0) begin
            fails++; $display("FAIL release_accept: got %b exp %b", obs(), 6'b1_101_0_0);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL drain: got valid %b ready %b exp valid 0 ready 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midflight();
        send(1'b1, 1'b1, 8'b0001_0000);
        tests++;
        if (obs() !== 6'b1_100_0_0 || dut.ptr !== 3'd5) begin
            fails++; $display("FAIL pre_reset: got %b ptr %0d exp %b ptr 5", obs(), dut.ptr, 6'b1_100_0_0);
        end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; d = 8'hFF; en = 1'b1; mode = 1'b1;
        tick();
        tests++;
        if (obs() !== 6'b0_000_0_0 || dut.ptr !== 3'd0) begin
            fails++; $display("FAIL mid_reset: got %b ptr %0d exp %b ptr 0", obs(), dut.ptr, 6'b0_000_0_0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_ready: got %b exp %b", in_ready, 1'b1);
        end
        send(1'b1, 1'b1, 8'hFF);
        tests++;
        if (obs() !== 6'b1_000_0_1 || dut.ptr !== 3'd1) begin
            fails++; $display("FAIL post_reset_rr: got %b ptr %0d exp %b ptr 1", obs(), dut.ptr, 6'b1_000_0_1);
        end
    endtask

    initial begin
        rst = 1'b1; d = '0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        test_reset();
        test_fixed();
        test_round_robin();
        test_no_encode();
        test_mode_switch();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
